a51_block_packer: RTL

- Upstream stage of the A5/1 stream-cipher datapath.
- Accepts a plaintext byte stream with valid/ready handshake and packs bytes MSB-first into 256-bit blocks.
- Presents each block with a 22-bit frame number and an 8-bit block index inside the frame, so the cipher stage can load its frame input and re-key every 256 blocks.
- Single-buffered. Each full block takes 32 input beats plus at least 1 hand-off cycle.

---
 rtl/a51_pkg.sv | 15 +
 rtl/a51_block_packer_if.sv | 38 +++
 rtl/a51_block_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 stream-cipher datapath.
// Holds the datapath-wide widths and the block packer FSM state type.
package a51_pkg;

  localparam int unsigned A51_BLK_W      = 256;
  localparam int unsigned A51_FN_W       = 22;
  localparam int unsigned A51_KEY_W      = 64;
  localparam int unsigned A51_FRAME_BLKS = 256;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } a51_state_e;

endpackage

// File: rtl/a51_block_packer_if.sv
// Byte-in / block-out bus of the A5/1 block packer.
//   in_*   : plaintext byte stream (valid/ready, in_last marks message end)
//   blk_*  : packed block with byte count, message-end flag, index in frame
//   frame_num / frame_start : frame tag used by the cipher stage to re-key
// slave modport is the packer side, master modport the surrounding logic.
interface a51_block_packer_if
  import a51_pkg::*;
#(
  parameter int unsigned BLK_W = A51_BLK_W,
  parameter int unsigned FN_W  = A51_FN_W
) ();

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic [5:0]       blk_nbytes;
  logic             blk_last;
  logic [7:0]       blk_idx;
  logic [FN_W-1:0]  frame_num;
  logic             frame_start;

  modport slave (
    input  in_data, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_nbytes, blk_last,
           blk_idx, frame_num, frame_start
  );

  modport master (
    output in_data, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_nbytes, blk_last,
           blk_idx, frame_num, frame_start
  );

endinterface

// File: rtl/a51_block_packer.sv
// A5/1 block packer: packs a plaintext byte stream MSB-first into BLK_W-bit
// blocks and tags each block with its index inside the current frame and the
// frame number. Single-buffered: FILL collects bytes, HOLD presents the block.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : a51_block_packer_if.slave (byte input, block output, frame tag)
module a51_block_packer
  import a51_pkg::*;
#(
  parameter int unsigned     BLK_W      = A51_BLK_W,
  parameter int unsigned     FRAME_BLKS = A51_FRAME_BLKS,
  parameter int unsigned     FN_W       = A51_FN_W,
  parameter logic [FN_W-1:0] FN_INIT    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  a51_block_packer_if.slave   bus
);

  localparam int unsigned NB    = BLK_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NB - 1);

  a51_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [BLK_W-1:0] data_q, data_d;
  logic [5:0]       nbytes_q;
  logic             last_q;
  logic [7:0]       idx_q;
  logic [FN_W-1:0]  fn_q;

  logic             in_ready_c;
  logic             blk_valid_c;
  logic             accept;
  logic             closing;
  logic             handoff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (accept && closing) state_d = HOLD;
      HOLD: if (bus.blk_ready)     state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs decoded from state only, so neither blk_ready nor in_valid
  // reaches a handshake output combinationally.
  always_comb begin
    in_ready_c  = 1'b0;
    blk_valid_c = 1'b0;
    unique case (state_q)
      FILL: in_ready_c  = run_q;
      HOLD: blk_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign accept  = bus.in_valid && in_ready_c;
  assign closing = (cnt_q == LAST_LANE) || bus.in_last;
  assign handoff = blk_valid_c && bus.blk_ready;

  // Keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= closing ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Byte-lane write decoder; a hand-off wipes every lane so short blocks
  // read zero in their unwritten lanes.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign data_d[BLK_W-1-8*i -: 8] =
      handoff                             ? 8'h00 :
      (accept && (cnt_q == CNT_W'(i)))    ? bus.in_data :
                                            data_q[BLK_W-1-8*i -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  // Block descriptor and frame tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbytes_q <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      fn_q     <= FN_INIT;
    end else begin
      if (accept && closing) begin
        nbytes_q <= (cnt_q == LAST_LANE) ? 6'd0 : 6'(cnt_q) + 6'd1;
        last_q   <= bus.in_last;
      end
      if (handoff) begin
        if (last_q || (idx_q == 8'(FRAME_BLKS - 1))) begin
          idx_q <= '0;
          fn_q  <= fn_q + FN_W'(1);
        end else begin
          idx_q <= idx_q + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.blk_valid   = blk_valid_c;
  assign bus.blk_data    = data_q;
  assign bus.blk_nbytes  = nbytes_q;
  assign bus.blk_last    = last_q;
  assign bus.blk_idx     = idx_q;
  assign bus.frame_num   = fn_q;
  assign bus.frame_start = blk_valid_c && (idx_q == 8'd0);

endmodule
